// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Included by pc_sequencer and its next-PC select mux.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HALT
   } state_t;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_TRAP,
      SEL_MISALIGN
   } sel_t;

   localparam int unsigned INSTR_BYTES = 4;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority mux for the next PC: trap > jump > branch > sequential,
// with misaligned redirect targets diverted to the trap vector.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic [WIDTH-1:0] pc,
   input  logic             trap,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   output sel_t             sel,
   output logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] epc_next,
   output logic             misaligned
);

   always_comb begin
      sel      = SEL_SEQ;
      next_pc  = pc + WIDTH'(INSTR_BYTES);
      epc_next = pc;
      if (trap) begin
         sel     = SEL_TRAP;
         next_pc = TRAP_VECTOR;
      end else if (jump) begin
         if (is_misaligned(jump_target[1:0])) begin
            sel      = SEL_MISALIGN;
            next_pc  = TRAP_VECTOR;
            epc_next = jump_target;
         end else begin
            sel     = SEL_JUMP;
            next_pc = jump_target;
         end
      end else if (branch_taken) begin
         if (is_misaligned(branch_target[1:0])) begin
            sel      = SEL_MISALIGN;
            next_pc  = TRAP_VECTOR;
            epc_next = branch_target;
         end else begin
            sel     = SEL_BRANCH;
            next_pc = branch_target;
         end
      end
   end

   assign misaligned = (sel == SEL_MISALIGN);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller owning the PC: issues imem requests, selects the next PC
// and records trap/misalignment state for the single-cycle core.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no fetch request
// FETCH | requesting instructions; PC advances on each accept
// HALT  | fetch stopped, PC/epc/retire_count frozen until reset
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             halt,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             trap,
   input  logic             imem_ready,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   output logic [WIDTH-1:0] pc,
   output logic             instr_valid,
   output logic             misaligned,
   output logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] retire_count
);

   state_t           state, state_next;
   sel_t             sel;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] epc_next;
   logic             mis_sel;
   logic             accept;
   logic             faulted;

   pc_next_sel #(
      .WIDTH       (WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .pc            (pc),
      .trap          (trap),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .sel           (sel),
      .next_pc       (pc_next),
      .epc_next      (epc_next),
      .misaligned    (mis_sel)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= BOOT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = FETCH;
         FETCH:   if (halt) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = BOOT;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      if (state == FETCH) imem_req = !stall && !halt;
      instr_valid = imem_req && imem_ready;
   end

   assign accept    = instr_valid;
   assign faulted   = (sel == SEL_TRAP) || (sel == SEL_MISALIGN);
   assign imem_addr = pc;

   // misaligned is a registered pulse so no target-to-output path exists
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc           <= RESET_VECTOR;
         epc          <= '0;
         retire_count <= '0;
         misaligned   <= 1'b0;
      end else begin
         misaligned <= 1'b0;
         if (accept) begin
            pc         <= pc_next;
            misaligned <= mis_sel;
            if (faulted) epc          <= epc_next;
            else         retire_count <= retire_count + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a reference model pushes expected
// post-edge state into a queue that is popped and compared after each edge.
module tb_pc_sequencer;

   localparam logic [31:0] RSTV  = 32'h0000_0000;
   localparam logic [31:0] TRAPV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, halt, branch_taken, jump, trap, imem_ready;
   logic [31:0] branch_target, jump_target;
   logic        imem_req, instr_valid, misaligned;
   logic [31:0] imem_addr, pc, epc, retire_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic [31:0] rc;
      logic        mis;
      int          st;
   } exp_t;

   exp_t q[$];
   exp_t m;

   always #5 clk = ~clk;

   pc_sequencer #(
      .WIDTH        (32),
      .RESET_VECTOR (RSTV),
      .TRAP_VECTOR  (TRAPV)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .halt          (halt),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .trap          (trap),
      .imem_ready    (imem_ready),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .pc            (pc),
      .instr_valid   (instr_valid),
      .misaligned    (misaligned),
      .epc           (epc),
      .retire_count  (retire_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m.pc  = RSTV;
      m.epc = '0;
      m.rc  = '0;
      m.mis = 1'b0;
      m.st  = 0;
   endtask

   // args: stall, halt, ready, trap, jump, jump_target, branch, branch_target
   task automatic step(input logic st_i, input logic hl_i, input logic rdy_i,
                       input logic tr_i, input logic jp_i, input logic [31:0] jt_i,
                       input logic br_i, input logic [31:0] bt_i);
      exp_t        nx, got;
      logic        req, acc, redirect;
      logic [31:0] tgt;
      stall = st_i; halt = hl_i; imem_ready = rdy_i; trap = tr_i;
      jump = jp_i; jump_target = jt_i; branch_taken = br_i; branch_target = bt_i;
      #1;
      req = (m.st == 1) && !st_i && !hl_i;
      acc = req && rdy_i;
      chk("imem_req", {31'b0, imem_req}, {31'b0, req});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, acc});
      chk("imem_addr", imem_addr, m.pc);
      nx = m;
      nx.mis = 1'b0;
      if (m.st == 0) nx.st = 1;
      else if (m.st == 1 && hl_i) nx.st = 2;
      if (acc) begin
         redirect = jp_i || br_i;
         tgt = jp_i ? jt_i : bt_i;
         if (tr_i) begin
            nx.pc  = TRAPV;
            nx.epc = m.pc;
         end else if (redirect && tgt[1:0] != 2'b00) begin
            nx.pc  = TRAPV;
            nx.epc = tgt;
            nx.mis = 1'b1;
         end else begin
            nx.pc = redirect ? tgt : m.pc + 32'd4;
            nx.rc = m.rc + 32'd1;
         end
      end
      q.push_back(nx);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("pc", pc, got.pc);
      chk("epc", epc, got.epc);
      chk("retire_count", retire_count, got.rc);
      chk("misaligned", {31'b0, misaligned}, {31'b0, got.mis});
      m = got;
   endtask

   initial begin
      reset = 1'b0;
      stall = 0; halt = 0; branch_taken = 0; jump = 0; trap = 0; imem_ready = 0;
      branch_target = '0; jump_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, RSTV);
      chk("rst_epc", epc, 32'h0);
      chk("rst_rc", retire_count, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'h0);
      reset = 1'b1;

      step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);            // BOOT cycle, no request
      repeat (3) step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0); // 0 -> 4 -> 8 -> C
      chk("rc_after_3", retire_count, 32'd3);
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);            // memory not ready
      step(0, 0, 1, 0, 1, 32'h8, 0, 32'h0);            // jump back to 0x8
      step(0, 0, 1, 0, 1, 32'h80, 1, 32'h40);          // jump beats branch
      chk("jump_wins", pc, 32'h80);
      step(0, 0, 1, 0, 1, 32'h10, 0, 32'h0);
      step(0, 0, 1, 1, 1, 32'h44, 0, 32'h0);           // trap beats jump
      chk("trap_epc", epc, 32'h10);
      step(0, 0, 1, 0, 0, 32'h0, 1, 32'h20);
      step(0, 0, 1, 0, 1, 32'h42, 0, 32'h0);           // misaligned jump
      chk("mis_epc", epc, 32'h42);
      repeat (3) step(1, 0, 1, 0, 0, 32'h0, 1, 32'h200);
      step(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
      step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);            // wraps to 0
      chk("wrap_pc", pc, 32'h0);
      step(0, 0, 1, 0, 0, 32'h0, 1, 32'h31);           // misaligned branch
      step(0, 0, 1, 1, 1, 32'h3, 0, 32'h0);            // trap skips alignment
      step(0, 0, 1, 0, 0, 32'h0, 1, 32'h30);
      step(0, 1, 1, 0, 1, 32'h80, 0, 32'h0);           // halt at 0x30
      repeat (2) step(0, 0, 1, 0, 1, 32'h80, 0, 32'h0);
      chk("halt_pc", pc, 32'h30);

      #2 reset = 1'b0;
      #1;
      chk("async_pc", pc, RSTV);
      chk("async_rc", retire_count, 32'h0);
      chk("async_epc", epc, 32'h0);
      chk("async_req", {31'b0, imem_req}, 32'h0);
      model_reset();
      #1 reset = 1'b1;
      step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);

      stall = 0; halt = 0; imem_ready = 0; jump = 0; branch_taken = 0; trap = 0;
      #1;
      chk("fetch_req", {31'b0, imem_req}, 32'h1);
      reset = 1'b0;
      #1;
      chk("midfetch_req", {31'b0, imem_req}, 32'h0);
      chk("midfetch_pc", pc, RSTV);
      chk("midfetch_rc", retire_count, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
